// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: shares one AES block engine between two requesters.
// A block and its command are accepted from the round-robin winner, the core
// gets a one-cycle start pulse, and the arbiter waits for core_done under a
// watchdog. The result goes back to the requester that issued the block.
// Only one transaction is in flight at a time.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   rN_req_*               request channel of requester N (valid/ready, cmd, blk)
//   rN_rsp_*               response channel of requester N (valid/ready, blk, err)
//   core_start/cmd/blk_in  start pulse and held operands for the AES core
//   core_done/blk_out      completion strobe and result from the AES core
//   busy                   high whenever the arbiter is not idle
//   owner                  requester of the current or most recent grant
module aes_core_arbiter #(
  parameter int unsigned DATA_WIDTH     = 128,
  parameter int unsigned CMD_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  r0_req_valid,
  output logic                  r0_req_ready,
  input  logic [CMD_WIDTH-1:0]  r0_req_cmd,
  input  logic [DATA_WIDTH-1:0] r0_req_blk,
  output logic                  r0_rsp_valid,
  input  logic                  r0_rsp_ready,
  output logic [DATA_WIDTH-1:0] r0_rsp_blk,
  output logic                  r0_rsp_err,
  input  logic                  r1_req_valid,
  output logic                  r1_req_ready,
  input  logic [CMD_WIDTH-1:0]  r1_req_cmd,
  input  logic [DATA_WIDTH-1:0] r1_req_blk,
  output logic                  r1_rsp_valid,
  input  logic                  r1_rsp_ready,
  output logic [DATA_WIDTH-1:0] r1_rsp_blk,
  output logic                  r1_rsp_err,
  output logic                  core_start,
  output logic [CMD_WIDTH-1:0]  core_cmd,
  output logic [DATA_WIDTH-1:0] core_blk_in,
  input  logic                  core_done,
  input  logic [DATA_WIDTH-1:0] core_blk_out,
  output logic                  busy,
  output logic                  owner
);

  localparam logic [15:0] TimeoutMax  = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q;
  logic [15:0]           cnt_q;
  logic                  last_grant_q;
  logic                  owner_q;
  logic                  err_q;
  logic                  start_q;
  logic [CMD_WIDTH-1:0]  cmd_q;
  logic [DATA_WIDTH-1:0] blk_in_q;
  logic [DATA_WIDTH-1:0] rsp_blk_q;

  logic sel;
  logic idle_ok;
  logic req_hs;
  logic rsp_ack;

  // Grant selection: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    sel = 1'b0;
    if (r0_req_valid && r1_req_valid) begin
      sel = ~last_grant_q;
    end else begin
      sel = r1_req_valid;
    end
    // Gated by aresetn so ready is low for the whole time reset is asserted.
    idle_ok      = aresetn && (state_q == StIdle);
    r0_req_ready = idle_ok && r0_req_valid && !sel;
    r1_req_ready = idle_ok && r1_req_valid && sel;
    req_hs       = r0_req_ready || r1_req_ready;
    rsp_ack      = owner_q ? r1_rsp_ready : r0_rsp_ready;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      err_q        <= 1'b0;
      start_q      <= 1'b0;
      cmd_q        <= '0;
      blk_in_q     <= '0;
      rsp_blk_q    <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_hs) begin
            cmd_q        <= sel ? r1_req_cmd : r0_req_cmd;
            blk_in_q     <= sel ? r1_req_blk : r0_req_blk;
            owner_q      <= sel;
            last_grant_q <= sel;
            start_q      <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q != TimeoutMax) begin
            cnt_q <= cnt_q + 16'd1;
          end
          // A done strobe wins over a watchdog expiry in the same cycle.
          if (core_done) begin
            rsp_blk_q <= core_blk_out;
            err_q     <= 1'b0;
            state_q   <= StResp;
          end else if (cnt_q == TimeoutLast) begin
            rsp_blk_q <= '0;
            err_q     <= 1'b1;
            state_q   <= StResp;
          end
        end
        StResp: begin
          if (rsp_ack) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign r0_rsp_valid = (state_q == StResp) && !owner_q;
  assign r1_rsp_valid = (state_q == StResp) && owner_q;
  assign r0_rsp_err   = r0_rsp_valid && err_q;
  assign r1_rsp_err   = r1_rsp_valid && err_q;
  assign r0_rsp_blk   = rsp_blk_q;
  assign r1_rsp_blk   = rsp_blk_q;
  assign core_start   = start_q;
  assign core_cmd     = cmd_q;
  assign core_blk_in  = blk_in_q;
  assign busy         = (state_q != StIdle);
  assign owner        = owner_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Self-checking bench for aes_core_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a timestamp-level model.
// A second instance with an 8-cycle watchdog covers timeout behaviour.
module tb_aes_core_arbiter;

  logic         aclk, aresetn;
  logic         r0_req_valid, r1_req_valid, r0_rsp_ready, r1_rsp_ready;
  logic [31:0]  r0_req_cmd, r1_req_cmd;
  logic [127:0] r0_req_blk, r1_req_blk;
  logic         core_done;
  logic [127:0] core_blk_out;

  logic         r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid, r0_rsp_err, r1_rsp_err;
  logic [127:0] r0_rsp_blk, r1_rsp_blk, core_blk_in;
  logic [31:0]  core_cmd;
  logic         core_start, busy, owner;

  logic         w_r0_req_ready, w_r1_req_ready, w_r0_rsp_valid, w_r1_rsp_valid;
  logic         w_r0_rsp_err, w_r1_rsp_err, w_core_start, w_busy, w_owner;
  logic [127:0] w_r0_rsp_blk, w_r1_rsp_blk, w_core_blk_in;
  logic [31:0]  w_core_cmd;

  aes_core_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_cmd(r0_req_cmd),
    .r0_req_blk(r0_req_blk), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r0_rsp_blk(r0_rsp_blk), .r0_rsp_err(r0_rsp_err),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_cmd(r1_req_cmd),
    .r1_req_blk(r1_req_blk), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .r1_rsp_blk(r1_rsp_blk), .r1_rsp_err(r1_rsp_err),
    .core_start(core_start), .core_cmd(core_cmd), .core_blk_in(core_blk_in),
    .core_done(core_done), .core_blk_out(core_blk_out), .busy(busy), .owner(owner)
  );

  aes_core_arbiter #(.TIMEOUT_CYCLES(8)) dut_wd (
    .aclk(aclk), .aresetn(aresetn),
    .r0_req_valid(r0_req_valid), .r0_req_ready(w_r0_req_ready), .r0_req_cmd(r0_req_cmd),
    .r0_req_blk(r0_req_blk), .r0_rsp_valid(w_r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r0_rsp_blk(w_r0_rsp_blk), .r0_rsp_err(w_r0_rsp_err),
    .r1_req_valid(r1_req_valid), .r1_req_ready(w_r1_req_ready), .r1_req_cmd(r1_req_cmd),
    .r1_req_blk(r1_req_blk), .r1_rsp_valid(w_r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .r1_rsp_blk(w_r1_rsp_blk), .r1_rsp_err(w_r1_rsp_err),
    .core_start(w_core_start), .core_cmd(w_core_cmd), .core_blk_in(w_core_blk_in),
    .core_done(core_done), .core_blk_out(core_blk_out), .busy(w_busy), .owner(w_owner)
  );

  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  bit  use_wd = 0;
  bit  core_auto = 0, core_rand = 0, core_spur = 0, inj = 0;
  int  core_lat = 1;
  logic [127:0] inj_val;

  logic         s_r0_req_ready, s_r1_req_ready, s_core_start;
  logic [127:0] s_core_blk_in;
  assign s_r0_req_ready = use_wd ? w_r0_req_ready : r0_req_ready;
  assign s_r1_req_ready = use_wd ? w_r1_req_ready : r1_req_ready;
  assign s_core_start   = use_wd ? w_core_start : core_start;
  assign s_core_blk_in  = use_wd ? w_core_blk_in : core_blk_in;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  // Core model: returns ~blk a chosen number of cycles after start.
  initial begin
    bit           pend;
    int           due;
    logic [127:0] latched;
    pend = 0; due = 0; latched = '0;
    core_done = 1'b0;
    core_blk_out = '0;
    forever begin
      @(negedge aclk);
      core_done = 1'b0;
      if (s_core_start && core_auto) begin
        pend    = 1;
        due     = cyc + (core_rand ? int'($urandom_range(1, 12)) : core_lat);
        latched = s_core_blk_in;
      end
      if (inj) begin
        core_done = 1'b1;
        core_blk_out = inj_val;
        inj = 0;
      end else if (pend && cyc == due) begin
        core_done = 1'b1;
        core_blk_out = ~latched;
        pend = 0;
      end else if (!pend && core_spur && $urandom_range(0, 7) == 0) begin
        core_done = 1'b1;
        core_blk_out = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) @(negedge aclk);
  endtask

  task automatic wait_grant(input string name, output int got);
    got = -1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (s_r0_req_ready || s_r1_req_ready) begin
        got = s_r1_req_ready ? 1 : 0;
        return;
      end
      @(negedge aclk);
    end
    n_cmp++;
    n_err++;
    $display("FAIL %s_grant: got no ready within 20 cycles, expected a grant", name);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    core_auto = 0;
    core_spur = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (14) @(negedge aclk);
  endtask

  task automatic run_txn(input string name, input bit v0, input bit v1, input int lat,
                         input int exp_o, input logic [31:0] c0, input logic [127:0] b0,
                         input logic [31:0] c1, input logic [127:0] b1);
    int           got, t;
    logic [31:0]  ec;
    logic [127:0] eb;
    ec = exp_o ? c1 : c0;
    eb = exp_o ? b1 : b0;
    core_auto = 1; core_rand = 0; core_lat = lat;
    @(negedge aclk);
    r0_req_valid = v0; r0_req_cmd = c0; r0_req_blk = b0;
    r1_req_valid = v1; r1_req_cmd = c1; r1_req_blk = b1;
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    wait_grant(name, got);
    chk({name, "_grant"}, 128'(got), 128'(exp_o));
    chk({name, "_one_ready"}, 128'(r0_req_ready & r1_req_ready), 128'(0));
    t = cyc;
    goto(t + 1);
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    #1;
    chk({name, "_start"}, 128'(core_start), 128'(1));
    chk({name, "_core_cmd"}, 128'(core_cmd), 128'(ec));
    chk({name, "_core_blk"}, core_blk_in, eb);
    chk({name, "_owner"}, 128'(owner), 128'(exp_o));
    goto(t + 1 + lat); #1;
    chk({name, "_early_rsp"}, 128'(r0_rsp_valid | r1_rsp_valid), 128'(0));
    goto(t + 2 + lat); #1;
    chk({name, "_rsp_valid"}, 128'({r1_rsp_valid, r0_rsp_valid}), 128'(exp_o ? 2 : 1));
    chk({name, "_rsp_blk"}, exp_o ? r1_rsp_blk : r0_rsp_blk, ~eb);
    chk({name, "_rsp_err"}, 128'(r0_rsp_err | r1_rsp_err), 128'(0));
    goto(t + 3 + lat); #1;
    chk({name, "_idle"}, 128'(busy), 128'(0));
  endtask

  typedef struct {
    bit v0;
    bit v1;
    int lat;
    int exp_o;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int           got, t;
    logic [31:0]  c1;
    logic [127:0] b1, b0;
    bit           pend[2];
    logic [31:0]  pc[2];
    logic [127:0] pb[2];
    bit           m_busy;
    int           m_last, m_owner, m_t, m_rsp_from, g;
    logic [31:0]  m_cmd;
    logic [127:0] m_blk;
    bit           in_rsp, rdy;

    tbl[0]  = '{1, 1, 4, 0};  tbl[1]  = '{1, 1, 6, 1};  tbl[2]  = '{1, 1, 1, 0};
    tbl[3]  = '{1, 1, 10, 1}; tbl[4]  = '{1, 1, 2, 0};  tbl[5]  = '{1, 1, 5, 1};
    tbl[6]  = '{1, 0, 3, 0};  tbl[7]  = '{1, 0, 2, 0};  tbl[8]  = '{0, 1, 7, 1};
    tbl[9]  = '{1, 1, 3, 0};  tbl[10] = '{0, 1, 1, 1};  tbl[11] = '{1, 1, 2, 0};

    aresetn = 1'b0;
    r0_req_valid = 1'b0; r1_req_valid = 1'b0;
    r0_req_cmd = '0; r1_req_cmd = '0; r0_req_blk = '0; r1_req_blk = '0;
    r0_rsp_ready = 1'b0; r1_rsp_ready = 1'b0;
    inj_val = '0;
    repeat (2) @(negedge aclk);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_start", 128'(core_start), 128'(0));
    chk("rst_rsp_valid", 128'({r0_rsp_valid, r1_rsp_valid}), 128'(0));
    chk("rst_err", 128'({r0_rsp_err, r1_rsp_err}), 128'(0));
    chk("rst_ready", 128'({r0_req_ready, r1_req_ready}), 128'(0));
    chk("rst_core_cmd", 128'(core_cmd), 128'(0));
    chk("rst_core_blk", core_blk_in, 128'(0));
    chk("rst_rsp_blk", r0_rsp_blk, 128'(0));
    chk("rst_owner", 128'(owner), 128'(0));
    @(negedge aclk);
    aresetn = 1'b1;

    // Single request with known data.
    run_txn("single", 1, 0, 10, 0, 32'h1, 128'h00112233445566778899aabbccddeeff, 32'h0, '0);
    chk("single_known_blk", r0_rsp_blk, 128'hffeeddccbbaa99887766554433221100);

    // Vector table: grant order and latency.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i].v0, tbl[i].v1, tbl[i].lat, tbl[i].exp_o,
              $urandom, {$urandom, $urandom, $urandom, $urandom},
              $urandom, {$urandom, $urandom, $urandom, $urandom});
    end

    // Response backpressure on requester 1.
    do_reset();
    core_auto = 1; core_rand = 0; core_lat = 3;
    b1 = {$urandom, $urandom, $urandom, $urandom};
    c1 = $urandom;
    @(negedge aclk);
    r1_req_valid = 1'b1; r1_req_cmd = c1; r1_req_blk = b1;
    r1_rsp_ready = 1'b0; r0_rsp_ready = 1'b1;
    wait_grant("bp", got);
    chk("bp_grant", 128'(got), 128'(1));
    t = cyc;
    goto(t + 1);
    r1_req_valid = 1'b0;
    r0_req_valid = 1'b1; r0_req_cmd = $urandom; r0_req_blk = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 20; i++) begin
      goto(t + 5 + i); #1;
      chk("bp_rsp_valid", 128'(r1_rsp_valid), 128'(1));
      chk("bp_rsp_blk", r1_rsp_blk, ~b1);
      chk("bp_r0_ready", 128'(r0_req_ready), 128'(0));
    end
    goto(t + 25);
    r1_rsp_ready = 1'b1;
    goto(t + 26); #1;
    chk("bp_released", 128'(r1_rsp_valid), 128'(0));
    chk("bp_idle", 128'(busy), 128'(0));
    chk("bp_r0_ready_after", 128'(r0_req_ready), 128'(1));

    // Done/timeout collision on the 8-cycle watchdog instance.
    do_reset();
    use_wd = 1;
    core_auto = 1; core_lat = 8;
    b1 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge aclk);
    r1_req_valid = 1'b1; r1_req_cmd = $urandom; r1_req_blk = b1;
    r1_rsp_ready = 1'b1; r0_rsp_ready = 1'b0;
    wait_grant("coll", got);
    chk("coll_grant", 128'(got), 128'(1));
    t = cyc;
    goto(t + 1);
    r1_req_valid = 1'b0;
    #1;
    chk("coll_start", 128'(w_core_start), 128'(1));
    goto(t + 9); #1;
    chk("coll_early", 128'(w_r1_rsp_valid), 128'(0));
    goto(t + 10); #1;
    chk("coll_valid", 128'(w_r1_rsp_valid), 128'(1));
    chk("coll_err", 128'(w_r1_rsp_err), 128'(0));
    chk("coll_blk", w_r1_rsp_blk, ~b1);
    goto(t + 11); #1;
    chk("coll_idle", 128'(w_busy), 128'(0));

    // Watchdog expiry, then a late done strobe that must be ignored.
    core_auto = 0;
    @(negedge aclk);
    r0_req_valid = 1'b1; r0_req_cmd = $urandom; r0_req_blk = {$urandom, $urandom, $urandom, $urandom};
    r0_rsp_ready = 1'b0;
    wait_grant("wd", got);
    chk("wd_grant", 128'(got), 128'(0));
    t = cyc;
    goto(t + 1);
    r0_req_valid = 1'b0;
    goto(t + 9); #1;
    chk("wd_early", 128'(w_r0_rsp_valid), 128'(0));
    goto(t + 10); #1;
    chk("wd_valid", 128'(w_r0_rsp_valid), 128'(1));
    chk("wd_err", 128'(w_r0_rsp_err), 128'(1));
    chk("wd_blk", w_r0_rsp_blk, 128'(0));
    chk("wd_other", 128'({w_r1_rsp_valid, w_r1_rsp_err}), 128'(0));
    goto(t + 12); #1;
    inj_val = {4{32'ha5a55a5a}};
    inj = 1;
    goto(t + 14); #1;
    chk("wd_late_blk", w_r0_rsp_blk, 128'(0));
    chk("wd_late_valid", 128'(w_r0_rsp_valid), 128'(1));
    chk("wd_late_err", 128'(w_r0_rsp_err), 128'(1));
    r0_rsp_ready = 1'b1;
    do_reset();
    use_wd = 0;

    // Reset pulse four cycles after core_start.
    core_auto = 1; core_rand = 0; core_lat = 10;
    @(negedge aclk);
    r0_req_valid = 1'b1; r0_req_cmd = $urandom; r0_req_blk = {$urandom, $urandom, $urandom, $urandom};
    r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
    wait_grant("mrst", got);
    t = cyc;
    goto(t + 1);
    r0_req_valid = 1'b0;
    goto(t + 5);
    aresetn = 1'b0;
    #1;
    chk("mrst_busy", 128'(busy), 128'(0));
    chk("mrst_outs", 128'({core_start, r0_rsp_valid, r1_rsp_valid, r0_rsp_err, owner}), 128'(0));
    chk("mrst_core_cmd", 128'(core_cmd), 128'(0));
    chk("mrst_core_blk", core_blk_in, 128'(0));
    chk("mrst_rsp_blk", r0_rsp_blk, 128'(0));
    goto(t + 6);
    aresetn = 1'b1;
    for (int i = 6; i < 16; i++) begin
      goto(t + i); #1;
      chk("mrst_no_rsp", 128'({r0_rsp_valid, r1_rsp_valid, busy}), 128'(0));
    end
    @(negedge aclk);
    r0_req_valid = 1'b1; r1_req_valid = 1'b1;
    wait_grant("mrst_tie", got);
    chk("mrst_tie_grant", 128'(got), 128'(0));
    do_reset();

    // Randomized traffic against a timestamp model.
    pend[0] = 0; pend[1] = 0;
    pc[0] = '0; pc[1] = '0; pb[0] = '0; pb[1] = '0;
    m_busy = 0; m_last = 1; m_owner = 0; m_t = 0; m_rsp_from = 0;
    m_cmd = '0; m_blk = '0;
    core_auto = 1; core_rand = 1; core_spur = 1;
    for (int i = 0; i < 400; i++) begin
      @(negedge aclk);
      for (int x = 0; x < 2; x++) begin
        if (!pend[x] && $urandom_range(0, 2) == 0) begin
          pend[x] = 1;
          pc[x] = $urandom;
          pb[x] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      r0_req_valid = pend[0]; r0_req_cmd = pc[0]; r0_req_blk = pb[0];
      r1_req_valid = pend[1]; r1_req_cmd = pc[1]; r1_req_blk = pb[1];
      r0_rsp_ready = ($urandom_range(0, 3) != 0);
      r1_rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = -1;
      if (!m_busy) begin
        if (pend[0] && pend[1]) g = (m_last == 1) ? 0 : 1;
        else if (pend[0]) g = 0;
        else if (pend[1]) g = 1;
      end
      in_rsp = m_busy && m_rsp_from != 0 && cyc >= m_rsp_from;
      chk("rnd_r0_ready", 128'(r0_req_ready), 128'(g == 0));
      chk("rnd_r1_ready", 128'(r1_req_ready), 128'(g == 1));
      chk("rnd_start", 128'(core_start), 128'(m_busy && cyc == m_t + 1));
      if (m_busy && cyc == m_t + 1) begin
        chk("rnd_core_cmd", 128'(core_cmd), 128'(m_cmd));
        chk("rnd_core_blk", core_blk_in, m_blk);
      end
      chk("rnd_r0_rsp_valid", 128'(r0_rsp_valid), 128'(in_rsp && m_owner == 0));
      chk("rnd_r1_rsp_valid", 128'(r1_rsp_valid), 128'(in_rsp && m_owner == 1));
      chk("rnd_err", 128'({r0_rsp_err, r1_rsp_err}), 128'(0));
      if (in_rsp) begin
        chk("rnd_r0_rsp_blk", r0_rsp_blk, ~m_blk);
        chk("rnd_r1_rsp_blk", r1_rsp_blk, ~m_blk);
      end
      chk("rnd_busy", 128'(busy), 128'(m_busy));
      chk("rnd_owner", 128'(owner), 128'(m_owner));
      rdy = m_owner ? r1_rsp_ready : r0_rsp_ready;
      if (!m_busy) begin
        if (g >= 0) begin
          m_busy = 1; m_t = cyc; m_owner = g; m_last = g; m_rsp_from = 0;
          m_cmd = pc[g]; m_blk = pb[g]; pend[g] = 0;
        end
      end else if (m_rsp_from == 0) begin
        if (core_done && cyc >= m_t + 2) m_rsp_from = cyc + 1;
      end else if (cyc >= m_rsp_from && rdy) begin
        m_busy = 0;
      end
    end
    core_spur = 0;
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
